// File: rtl/instr_seq_if.sv
// Issue channel between the instruction sequencer and the control-unit decoder.
// The master drives the {opcode, operand} word and valid; the slave returns ready.
interface instr_seq_if;
    logic [3:0] instr;
    logic [3:0] operand;
    logic       instr_valid;
    logic       instr_ready;

    modport master (output instr, output operand, output instr_valid, input instr_ready);
    modport slave  (input instr, input operand, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_sequencer.sv
// Program store, program counter and issue stage for the 4-bit processor.
// JMP and HALT are consumed here; every other opcode is forwarded unchanged.
module instr_sequencer #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              start,
    input  logic              stop,
    instr_seq_if.master       bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t     state, state_nx;
    logic [7:0] mem [DEPTH];
    logic [7:0] word;
    logic [3:0] instr_q, operand_q;
    logic       valid_q;
    logic       fetch, accept, launch;

    assign word    = mem[pc];
    assign accept  = valid_q && bus.instr_ready;
    assign fetch   = (state == RUN) && (!valid_q || bus.instr_ready);
    // launch already excludes stop so the datapath and FSM agree on priority
    assign launch  = !stop && (state != RUN) && start && !valid_q;

    assign bus.instr       = instr_q;
    assign bus.operand     = operand_q;
    assign bus.instr_valid = valid_q;

    always_ff @(posedge clk) begin
        if (prog_we && state == IDLE)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, HALTED: if (start && !valid_q) state_nx = RUN;
                RUN:          if (fetch && word[7:4] == OP_HALT) state_nx = HALTED;
                default:      state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            HALTED:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            instr_q      <= '0;
            operand_q    <= '0;
            valid_q      <= 1'b0;
            issued_count <= '0;
        end else begin
            if (stop) begin
                valid_q <= 1'b0;
                pc      <= '0;
            end else if (launch) begin
                pc <= '0;
            end else if (fetch) begin
                if (word[7:4] == OP_JMP) begin
                    pc      <= word[ADDR_W-1:0];
                    valid_q <= 1'b0;
                end else if (word[7:4] == OP_HALT) begin
                    valid_q <= 1'b0;
                end else begin
                    instr_q   <= word[7:4];
                    operand_q <= word[3:0];
                    valid_q   <= 1'b1;
                    pc        <= pc + PC_ONE;
                end
            end else if (accept) begin
                valid_q <= 1'b0;
            end

            // A handshake still counts in the cycle stop is raised
            if (launch)
                issued_count <= '0;
            else if (accept && issued_count != CNT_MAX)
                issued_count <= issued_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected issued words are queued as each
// program is started and retired by a monitor on every completed handshake.
module tb_instr_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] pc;
    logic       busy, done;
    logic [7:0] issued_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    instr_seq_if bus ();

    instr_sequencer #(.ADDR_W(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .start        (start),
        .stop         (stop),
        .bus          (bus.master),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (!rst && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $error("FAIL unexpected_issue obs=%02h exp=none", {bus.instr, bus.operand});
            end else begin
                exp_w = sb.pop_front();
                assert ({bus.instr, bus.operand} === exp_w) else begin
                    bad++;
                    $error("FAIL issue_word obs=%02h exp=%02h", {bus.instr, bus.operand}, exp_w);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt_run();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_word", {bus.instr, bus.operand}, 0);
        chk("rst_pc", pc, 0);
        chk("rst_count", issued_count, 0);
        chk("rst_flags", {busy, done}, 0);
        rst = 1'b0;
        step();

        // basic run: three issues then HALT
        load(0, 8'h13); load(1, 8'h25); load(2, 8'h57); load(3, 8'hF0);
        sb.push_back(8'h13); sb.push_back(8'h25); sb.push_back(8'h57);
        bus.instr_ready = 1'b1;
        go();
        chk("t1_busy", busy, 1);
        chk("t1_no_valid_yet", bus.instr_valid, 0);
        step();
        chk("t1_first_valid", bus.instr_valid, 1);
        chk("t1_first_word", {bus.instr, bus.operand}, 8'h13);
        repeat (3) step();
        chk("t1_done", done, 1);
        chk("t1_count", issued_count, 3);
        chk("t1_pc", pc, 3);
        chk("t1_valid_clear", bus.instr_valid, 0);

        // restart from HALTED with backpressure, then async reset mid-run
        bus.instr_ready = 1'b0;
        go();
        chk("t2_count_clear", issued_count, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_word", {bus.instr, bus.operand}, 8'h13);
            chk("t2_hold_pc", pc, 1);
            chk("t2_hold_count", issued_count, 0);
            chk("t2_hold_valid", bus.instr_valid, 1);
            step();
        end
        sb.push_back(8'h13);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("t2_count_after", issued_count, 1);
        chk("t2_next_word", {bus.instr, bus.operand}, 8'h25);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_valid", bus.instr_valid, 0);
        chk("t5_async_word", {bus.instr, bus.operand}, 0);
        chk("t5_async_pc", pc, 0);
        chk("t5_async_count", issued_count, 0);
        chk("t5_async_flags", {busy, done}, 0);
        rst = 1'b0;
        step();
        sb.push_back(8'h13); sb.push_back(8'h25); sb.push_back(8'h57);
        bus.instr_ready = 1'b1;
        go();
        step();
        repeat (3) step();
        chk("t5_rerun_done", done, 1);
        chk("t5_rerun_count", issued_count, 3);
        halt_run();

        // JMP skips mem[2] with one bubble cycle
        load(0, 8'h61); load(1, 8'h73); load(2, 8'h22); load(3, 8'hF0);
        sb.push_back(8'h61);
        go();
        step();
        chk("t3_word", {bus.instr, bus.operand}, 8'h61);
        step();
        chk("t3_bubble", bus.instr_valid, 0);
        chk("t3_jmp_pc", pc, 3);
        step();
        chk("t3_done", done, 1);
        chk("t3_count", issued_count, 1);
        halt_run();

        // undefined opcode passes through; JMP to itself spins silently
        load(0, 8'h9A); load(1, 8'h71);
        sb.push_back(8'h9A);
        go();
        step();
        step();
        repeat (5) step();
        chk("t7_spin_valid", bus.instr_valid, 0);
        chk("t7_spin_pc", pc, 1);
        chk("t7_spin_busy", busy, 1);
        chk("t7_spin_count", issued_count, 1);
        halt_run();
        chk("t7_stop_idle", {busy, done}, 0);
        chk("t7_stop_pc", pc, 0);
        chk("t7_stop_count", issued_count, 1);

        // 16 NOPs, 20 back-to-back issues across the pc wrap
        for (int a = 0; a < 16; a++) load(4'(a), 8'h00);
        for (int i = 0; i < 20; i++) sb.push_back(8'h00);
        bus.instr_ready = 1'b1;
        go();
        step();
        chk("t4_pc_first", pc, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_pc_wrap", pc, (i + 2) % 16);
        end
        bus.instr_ready = 1'b0;
        chk("t4_count", issued_count, 20);
        chk("t4_pending", bus.instr_valid, 1);

        // program write during RUN is ignored
        prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'hF0;
        step();
        prog_we = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(8'h00);
        bus.instr_ready = 1'b1;
        repeat (3) step();
        bus.instr_ready = 1'b0;
        chk("t6_still_busy", {busy, done}, 2'b10);
        chk("t6_count", issued_count, 23);
        chk("t6_pc", pc, 8);

        // stop beats start in the same cycle
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("t6_stop_flags", {busy, done}, 0);
        chk("t6_stop_valid", bus.instr_valid, 0);
        chk("t6_stop_pc", pc, 0);
        chk("t6_stop_count", issued_count, 23);
        step();
        chk("t6_stays_idle", busy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
